bsg_fsb_hop_out_arb: RTL and testbench

- Outbound arbiter for one front-side-bus ring hop.
- Shares the single downstream bus segment between two sources:
  - channel 0: upstream pass-through traffic leaving the hop-in register stage;
  - channel 1: local node injection.
- Arbitration is round-robin, with packet locking so multi-beat packets are never interleaved.
- Downstream flow control is credit-based, because downstream hop-in stages have no ready signal.

---
 rtl/bsg_fsb_hop_out_arb.sv | 128 ++++++++++++
 tb/tb_bsg_fsb_hop_out_arb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bsg_fsb_hop_out_arb.sv
// Outbound arbiter for one FSB ring hop: round-robin between pass-through and local
// traffic, with packet locking and credit-based downstream flow control.
module bsg_fsb_hop_out_arb #(
   parameter int width_p   = 16,
   parameter int credits_p = 4
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] up_data_i,
   input  logic               up_v_i,
   input  logic               up_last_i,
   output logic               up_ready_o,
   input  logic [width_p-1:0] loc_data_i,
   input  logic               loc_v_i,
   input  logic               loc_last_i,
   output logic               loc_ready_o,
   output logic [width_p-1:0] data_o,
   output logic               v_o,
   input  logic               credit_i,
   output logic [3:0]         credits_o,
   output logic               overflow_o
);

   localparam logic [3:0] credits_full = 4'(credits_p);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_e;

   state_e             state_reg, state_next;
   logic               rr_reg, rr_next;
   logic [3:0]         credits_reg, credits_next;
   logic               overflow_reg, overflow_next;
   logic [width_p-1:0] data_reg;
   logic               v_reg;

   logic               grant_up, grant_loc, have_credit;
   logic               xfer_up, xfer_loc, xfer, xfer_last;
   logic [width_p-1:0] xfer_data;

   // State register plus the downstream output stage and credit bookkeeping
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_reg    <= IDLE;
         rr_reg       <= 1'b0;
         credits_reg  <= credits_full;
         overflow_reg <= 1'b0;
         data_reg     <= '0;
         v_reg        <= 1'b0;
      end else begin
         state_reg    <= state_next;
         rr_reg       <= rr_next;
         credits_reg  <= credits_next;
         overflow_reg <= overflow_next;
         v_reg        <= xfer;
         if (xfer)
            data_reg <= xfer_data;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (xfer && !xfer_last) state_next = xfer_loc ? LOCK1 : LOCK0;
         LOCK0:   if (xfer_up && up_last_i) state_next = IDLE;
         LOCK1:   if (xfer_loc && loc_last_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: grants follow the lock; contention in IDLE resolved by rr pointer
   always_comb begin
      grant_up  = 1'b0;
      grant_loc = 1'b0;
      case (state_reg)
         IDLE: begin
            if (up_v_i && loc_v_i) begin
               grant_up  = ~rr_reg;
               grant_loc = rr_reg;
            end else begin
               grant_up  = up_v_i;
               grant_loc = loc_v_i;
            end
         end
         LOCK0:   grant_up  = 1'b1;
         LOCK1:   grant_loc = 1'b1;
         default: ;
      endcase
   end

   assign have_credit = (credits_reg != 4'd0);
   assign up_ready_o  = grant_up & have_credit;
   assign loc_ready_o = grant_loc & have_credit;
   assign xfer_up     = up_v_i & up_ready_o;
   assign xfer_loc    = loc_v_i & loc_ready_o;
   assign xfer        = xfer_up | xfer_loc;
   assign xfer_data   = xfer_loc ? loc_data_i : up_data_i;
   assign xfer_last   = xfer_loc ? loc_last_i : up_last_i;

   // End of packet hands priority to the channel that did not just send
   always_comb begin
      rr_next = rr_reg;
      if (xfer && xfer_last)
         rr_next = xfer_loc ? 1'b0 : 1'b1;
   end

   always_comb begin
      credits_next  = credits_reg;
      overflow_next = overflow_reg;
      if (xfer && !credit_i) begin
         credits_next = credits_reg - 4'd1;
      end else if (!xfer && credit_i) begin
         if (credits_reg == credits_full)
            overflow_next = 1'b1;
         else
            credits_next = credits_reg + 4'd1;
      end
   end

   assign data_o     = data_reg;
   assign v_o        = v_reg;
   assign credits_o  = credits_reg;
   assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_bsg_fsb_hop_out_arb.sv
// Directed bench for bsg_fsb_hop_out_arb: inputs change on the falling edge,
// registered outputs are sampled on the falling edge, readys #1 after inputs settle.
module tb_bsg_fsb_hop_out_arb;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic [15:0] up_data_i, loc_data_i;
   logic        up_v_i, up_last_i, loc_v_i, loc_last_i;
   logic        up_ready_o, loc_ready_o;
   logic [15:0] data_o;
   logic        v_o;
   logic        credit_i;
   logic [3:0]  credits_o;
   logic        overflow_o;

   int errors = 0;
   int checks = 0;

   bsg_fsb_hop_out_arb #(.width_p(16), .credits_p(4)) dut (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .up_data_i   (up_data_i),
      .up_v_i      (up_v_i),
      .up_last_i   (up_last_i),
      .up_ready_o  (up_ready_o),
      .loc_data_i  (loc_data_i),
      .loc_v_i     (loc_v_i),
      .loc_last_i  (loc_last_i),
      .loc_ready_o (loc_ready_o),
      .data_o      (data_o),
      .v_o         (v_o),
      .credit_i    (credit_i),
      .credits_o   (credits_o),
      .overflow_o  (overflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic idle_inputs();
      up_data_i = '0; up_v_i = 0; up_last_i = 0;
      loc_data_i = '0; loc_v_i = 0; loc_last_i = 0;
      credit_i = 0;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      reset_n_i = 0;
      idle_inputs();
      repeat (2) @(negedge clk_i);
      reset_n_i = 1;
   endtask

   task automatic test_reset();
      reset_n_i = 0;
      idle_inputs();
      repeat (2) @(negedge clk_i);
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v: got %0b want 0", v_o); end
      checks++; if (data_o !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", data_o); end
      checks++; if (credits_o !== 4'd4) begin errors++; $display("FAIL reset_credits: got %0d want 4", credits_o); end
      checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow_o); end
      reset_n_i = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         checks++;
         if (up_ready_o !== 1'b0 || loc_ready_o !== 1'b0 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: up_ready=%0b loc_ready=%0b v=%0b want 0 0 0", up_ready_o, loc_ready_o, v_o);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_alternation();
      logic [15:0] exp;
      do_reset();
      up_v_i = 1; up_last_i = 1; up_data_i = 16'hAAAA;
      loc_v_i = 1; loc_last_i = 1; loc_data_i = 16'h5555;
      #1;
      checks++;
      if (up_ready_o !== 1'b1 || loc_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL alt_first_grant: up_ready=%0b loc_ready=%0b want 1 0", up_ready_o, loc_ready_o);
      end
      for (int k = 0; k < 8; k++) begin
         credit_i = (k >= 3);
         @(negedge clk_i);
         exp = (k % 2 == 0) ? 16'hAAAA : 16'h5555;
         checks++;
         if (v_o !== 1'b1 || data_o !== exp) begin
            errors++;
            $display("FAIL alt_beat%0d: v=%0b data=%h want v=1 data=%h", k, v_o, data_o, exp);
         end
         $display("alt beat %0d data=%h", k, data_o);
      end
      checks++; if (credits_o !== 4'd1) begin errors++; $display("FAIL alt_credits: got %0d want 1", credits_o); end
      idle_inputs();
   endtask

   task automatic test_packet_lock();
      do_reset();
      loc_v_i = 1; loc_last_i = 0; loc_data_i = 16'h0001;
      @(negedge clk_i);
      checks++; if (v_o !== 1'b1 || data_o !== 16'h0001) begin errors++; $display("FAIL lock_beat1: v=%0b data=%h want 1 0001", v_o, data_o); end
      up_v_i = 1; up_last_i = 1; up_data_i = 16'hBBBB;
      loc_data_i = 16'h0002;
      #1;
      checks++; if (up_ready_o !== 1'b0 || loc_ready_o !== 1'b1) begin errors++; $display("FAIL lock_ready2: up=%0b loc=%0b want 0 1", up_ready_o, loc_ready_o); end
      @(negedge clk_i);
      checks++; if (v_o !== 1'b1 || data_o !== 16'h0002) begin errors++; $display("FAIL lock_beat2: v=%0b data=%h want 1 0002", v_o, data_o); end
      loc_v_i = 0;
      #1;
      checks++; if (up_ready_o !== 1'b0) begin errors++; $display("FAIL lock_bubble_ready: up_ready=%0b want 0", up_ready_o); end
      @(negedge clk_i);
      checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL lock_bubble_v: v=%0b want 0", v_o); end
      loc_v_i = 1; loc_last_i = 1; loc_data_i = 16'h0003;
      #1;
      checks++; if (up_ready_o !== 1'b0) begin errors++; $display("FAIL lock_ready3: up_ready=%0b want 0", up_ready_o); end
      @(negedge clk_i);
      checks++; if (v_o !== 1'b1 || data_o !== 16'h0003) begin errors++; $display("FAIL lock_beat3: v=%0b data=%h want 1 0003", v_o, data_o); end
      loc_v_i = 0;
      #1;
      checks++; if (up_ready_o !== 1'b1) begin errors++; $display("FAIL lock_release: up_ready=%0b want 1", up_ready_o); end
      @(negedge clk_i);
      checks++; if (v_o !== 1'b1 || data_o !== 16'hBBBB) begin errors++; $display("FAIL lock_up_beat: v=%0b data=%h want 1 bbbb", v_o, data_o); end
      $display("lock packet done data=%h credits=%0d", data_o, credits_o);
      idle_inputs();
   endtask

   task automatic test_credit_exhaustion();
      int beats = 0;
      do_reset();
      up_v_i = 1; up_last_i = 1;
      for (int k = 0; k < 6; k++) begin
         up_data_i = 16'h1000 + 16'(k);
         @(negedge clk_i);
         if (v_o === 1'b1) beats++;
      end
      checks++; if (beats != 4) begin errors++; $display("FAIL exh_beats: got %0d want 4", beats); end
      checks++; if (credits_o !== 4'd0) begin errors++; $display("FAIL exh_credits: got %0d want 0", credits_o); end
      checks++; if (up_ready_o !== 1'b0) begin errors++; $display("FAIL exh_ready: got %0b want 0", up_ready_o); end
      checks++; if (data_o !== 16'h1003) begin errors++; $display("FAIL exh_data: got %h want 1003", data_o); end
      credit_i = 1;
      #1;
      checks++; if (up_ready_o !== 1'b0) begin errors++; $display("FAIL exh_ready_on_credit: got %0b want 0", up_ready_o); end
      @(negedge clk_i);
      checks++; if (v_o !== 1'b0 || credits_o !== 4'd1) begin errors++; $display("FAIL exh_after_pulse: v=%0b credits=%0d want 0 1", v_o, credits_o); end
      credit_i = 0;
      #1;
      checks++; if (up_ready_o !== 1'b1) begin errors++; $display("FAIL exh_ready_restored: got %0b want 1", up_ready_o); end
      @(negedge clk_i);
      checks++; if (v_o !== 1'b1 || data_o !== 16'h1005 || credits_o !== 4'd0) begin errors++; $display("FAIL exh_resume: v=%0b data=%h credits=%0d want 1 1005 0", v_o, data_o, credits_o); end
      $display("exhaustion beats=%0d resume data=%h", beats, data_o);
      idle_inputs();
   endtask

   task automatic test_simultaneous();
      do_reset();
      up_v_i = 1; up_last_i = 1; up_data_i = 16'h0011;
      @(negedge clk_i);
      up_data_i = 16'h0012;
      @(negedge clk_i);
      checks++; if (credits_o !== 4'd2) begin errors++; $display("FAIL sim_pre_credits: got %0d want 2", credits_o); end
      up_data_i = 16'h0013; credit_i = 1;
      @(negedge clk_i);
      checks++; if (credits_o !== 4'd2 || v_o !== 1'b1 || data_o !== 16'h0013) begin errors++; $display("FAIL sim_credits: credits=%0d v=%0b data=%h want 2 1 0013", credits_o, v_o, data_o); end
      $display("simultaneous credits=%0d", credits_o);
      idle_inputs();
   endtask

   task automatic test_overflow();
      do_reset();
      credit_i = 1;
      @(negedge clk_i);
      credit_i = 0;
      checks++; if (overflow_o !== 1'b1 || credits_o !== 4'd4) begin errors++; $display("FAIL ovf_set: overflow=%0b credits=%0d want 1 4", overflow_o, credits_o); end
      repeat (3) @(negedge clk_i);
      checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", overflow_o); end
      reset_n_i = 0;
      #1;
      checks++; if (overflow_o !== 1'b0 || credits_o !== 4'd4) begin errors++; $display("FAIL ovf_clear: overflow=%0b credits=%0d want 0 4", overflow_o, credits_o); end
      $display("overflow cleared by reset");
      @(negedge clk_i);
      reset_n_i = 1;
   endtask

   initial begin
      test_reset();
      test_alternation();
      test_packet_lock();
      test_credit_exhaustion();
      test_simultaneous();
      test_overflow();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
